// File: rtl/ivalu_pkg.sv
// Shared encodings for the integer vector ALU: unit select, per-unit op codes
// and element-width codes.
package ivalu_pkg;

  localparam int OP_W = 7;
  localparam int EW_W = 2;

  typedef enum logic [1:0] {
    UNIT_ADD    = 2'b00,
    UNIT_CMP    = 2'b01,
    UNIT_MINMAX = 2'b10,
    UNIT_SHIFT  = 2'b11
  } unit_e;

  typedef enum logic [2:0] {
    ADD_WRAP  = 3'b000,
    SUB_WRAP  = 3'b001,
    ADD_SAT_S = 3'b010,
    ADD_SAT_U = 3'b011,
    SUB_SAT_S = 3'b100,
    SUB_SAT_U = 3'b101,
    AVG_U     = 3'b110,
    ADD_ZERO  = 3'b111
  } add_op_e;

  typedef enum logic [1:0] {
    CMP_EQ   = 2'b00,
    CMP_LT_S = 2'b01,
    CMP_LT_U = 2'b10,
    CMP_ZERO = 2'b11
  } cmp_op_e;

  typedef enum logic [1:0] {
    MM_MIN_S = 2'b00,
    MM_MAX_S = 2'b01,
    MM_MIN_U = 2'b10,
    MM_MAX_U = 2'b11
  } mm_op_e;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ZERO = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    EW_8      = 2'b00,
    EW_16     = 2'b01,
    EW_32     = 2'b10,
    EW_32_ALT = 2'b11
  } ew_e;

endpackage

// File: rtl/ivalu_lanes.sv
// Combinational SIMD lane arithmetic: every lane width is computed in parallel
// and the element width picks which packing drives the result.
module ivalu_lanes
  import ivalu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OP_W-1:0] op,
  input  logic [EW_W-1:0] ew,
  output logic [XLEN-1:0] result
);

  localparam int N8  = XLEN / 8;
  localparam int N16 = XLEN / 16;
  localparam int N32 = XLEN / 32;

  // One lane, evaluated in 34 bits so sums, differences and the average never
  // overflow before saturation or truncation back to lane width.
  function automatic logic [31:0] lane_fn(input logic [31:0] la, input logic [31:0] lb,
                                          input logic [OP_W-1:0] lop, input ew_e lew);
    logic [31:0] mask;
    logic [4:0]  sh;
    logic        a_neg, b_neg;
    logic [33:0] ua, ub, sa, sb, smax, smin;
    logic [33:0] sum_u, dif_u, sum_s, dif_s, sra_v, r;
    logic        eq, lt_s, lt_u;
    case (lew)
      EW_8: begin
        mask = 32'h0000_00FF; sh = {2'b00, lb[2:0]}; a_neg = la[7];  b_neg = lb[7];
      end
      EW_16: begin
        mask = 32'h0000_FFFF; sh = {1'b0, lb[3:0]};  a_neg = la[15]; b_neg = lb[15];
      end
      default: begin
        mask = 32'hFFFF_FFFF; sh = lb[4:0];          a_neg = la[31]; b_neg = lb[31];
      end
    endcase
    ua    = {2'b00, la & mask};
    ub    = {2'b00, lb & mask};
    sa    = a_neg ? (ua | ~{2'b00, mask}) : ua;
    sb    = b_neg ? (ub | ~{2'b00, mask}) : ub;
    smax  = {3'b000, mask[31:1]};
    smin  = ~smax;
    sum_u = ua + ub;
    dif_u = ua - ub;
    sum_s = sa + sb;
    dif_s = sa - sb;
    eq    = (ua == ub);
    lt_s  = $signed(sa) < $signed(sb);
    lt_u  = ua < ub;
    sra_v = $unsigned($signed(sa) >>> sh);
    r     = '0;
    case (unit_e'(lop[5:4]))
      UNIT_ADD: begin
        case (add_op_e'(lop[2:0]))
          ADD_WRAP:  r = sum_u;
          SUB_WRAP:  r = dif_u;
          ADD_SAT_S: r = ($signed(sum_s) > $signed(smax)) ? smax :
                         ($signed(sum_s) < $signed(smin)) ? smin : sum_s;
          ADD_SAT_U: r = (sum_u > {2'b00, mask}) ? {2'b00, mask} : sum_u;
          SUB_SAT_S: r = ($signed(dif_s) > $signed(smax)) ? smax :
                         ($signed(dif_s) < $signed(smin)) ? smin : dif_s;
          SUB_SAT_U: r = dif_u[33] ? '0 : dif_u;
          AVG_U:     r = (sum_u + 34'd1) >> 1;
          default:   r = '0;
        endcase
      end
      UNIT_CMP: begin
        case (cmp_op_e'(lop[1:0]))
          CMP_EQ:   r = eq   ? '1 : '0;
          CMP_LT_S: r = lt_s ? '1 : '0;
          CMP_LT_U: r = lt_u ? '1 : '0;
          default:  r = '0;
        endcase
      end
      UNIT_MINMAX: begin
        case (mm_op_e'(lop[1:0]))
          MM_MIN_S: r = lt_s ? sa : sb;
          MM_MAX_S: r = lt_s ? sb : sa;
          MM_MIN_U: r = lt_u ? ua : ub;
          default:  r = lt_u ? ub : ua;
        endcase
      end
      default: begin
        case (sh_op_e'(lop[1:0]))
          SH_SLL:  r = ua << sh;
          SH_SRL:  r = ua >> sh;
          SH_SRA:  r = sra_v;
          default: r = '0;
        endcase
      end
    endcase
    return r[31:0] & mask;
  endfunction

  logic [XLEN-1:0] res8, res16, res32;

  generate
    for (genvar gi = 0; gi < N8; gi++) begin : g_lane8
      logic [31:0] lane_full;
      logic        unused_hi;
      assign lane_full = lane_fn({24'd0, a[gi*8 +: 8]}, {24'd0, b[gi*8 +: 8]}, op, EW_8);
      assign res8[gi*8 +: 8] = lane_full[7:0];
      assign unused_hi = ^lane_full[31:8];
    end
    for (genvar gi = 0; gi < N16; gi++) begin : g_lane16
      logic [31:0] lane_full;
      logic        unused_hi;
      assign lane_full = lane_fn({16'd0, a[gi*16 +: 16]}, {16'd0, b[gi*16 +: 16]}, op, EW_16);
      assign res16[gi*16 +: 16] = lane_full[15:0];
      assign unused_hi = ^lane_full[31:16];
    end
    for (genvar gi = 0; gi < N32; gi++) begin : g_lane32
      assign res32[gi*32 +: 32] = lane_fn(a[gi*32 +: 32], b[gi*32 +: 32], op, EW_32);
    end
  endgenerate

  always_comb begin
    case (ew_e'(ew))
      EW_8:    result = res8;
      EW_16:   result = res16;
      default: result = res32;
    endcase
  end

endmodule

// File: rtl/ivalu_pipelined.sv
// Pipelined integer vector ALU: lane arithmetic feeds STAGES register stages
// under one global stall; flush kills every valid bit, including the output.
module ivalu_pipelined
  import ivalu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int ROB_W  = 5,
  parameter int DEST_W = 6
) (
  input  logic              core_clock_i,
  input  logic              core_reset_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [EW_W-1:0]   ew_i,
  input  logic [ROB_W-1:0]  rob_i,
  input  logic [DEST_W-1:0] dest_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              wb_valid_o,
  output logic [XLEN-1:0]   result_o,
  output logic [ROB_W-1:0]  rob_o,
  output logic [DEST_W-1:0] dest_o
);

  logic              advance;
  logic              accept;
  logic [XLEN-1:0]   lane_result;
  logic [STAGES-1:0] valid_reg;
  logic [XLEN-1:0]   result_reg [STAGES];
  logic [ROB_W-1:0]  rob_reg    [STAGES];
  logic [DEST_W-1:0] dest_reg   [STAGES];

  ivalu_lanes #(.XLEN(XLEN)) u_lanes (
    .a      (a_i),
    .b      (b_i),
    .op     (op_i),
    .ew     (ew_i),
    .result (lane_result)
  );

  // A full pipe can still move when the head is being consumed this edge.
  assign advance = !valid_o | ready_i;
  assign ready_o = advance;
  assign accept  = valid_i & advance & !flush_i;

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      valid_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        result_reg[k] <= '0;
        rob_reg[k]    <= '0;
        dest_reg[k]   <= '0;
      end
    end else begin
      if (flush_i) begin
        valid_reg <= '0;
      end else if (advance) begin
        valid_reg[0] <= accept;
        for (int k = 1; k < STAGES; k++) valid_reg[k] <= valid_reg[k-1];
      end
      if (advance) begin
        result_reg[0] <= lane_result;
        rob_reg[0]    <= rob_i;
        dest_reg[0]   <= dest_i;
        for (int k = 1; k < STAGES; k++) begin
          result_reg[k] <= result_reg[k-1];
          rob_reg[k]    <= rob_reg[k-1];
          dest_reg[k]   <= dest_reg[k-1];
        end
      end
    end
  end

  assign valid_o    = valid_reg[STAGES-1];
  assign result_o   = result_reg[STAGES-1];
  assign rob_o      = rob_reg[STAGES-1];
  assign dest_o     = dest_reg[STAGES-1];
  assign wb_valid_o = valid_o & (dest_o != '0);

endmodule

// File: tb/tb_ivalu_pipelined.sv
// Directed bench for ivalu_pipelined: lane arithmetic vectors, stall, flush,
// zero-destination writeback and mid-pipe reset.
module tb_ivalu_pipelined;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int ROB_W  = 5;
  localparam int DEST_W = 6;

  localparam logic [6:0] OP_ADD       = 7'h00;
  localparam logic [6:0] OP_ADD_SAT_S = 7'h02;
  localparam logic [6:0] OP_SUB_SAT_U = 7'h05;
  localparam logic [6:0] OP_AVG_U     = 7'h06;
  localparam logic [6:0] OP_ADD_ZERO  = 7'h07;
  localparam logic [6:0] OP_EQ        = 7'h10;
  localparam logic [6:0] OP_LT_U      = 7'h12;
  localparam logic [6:0] OP_MAX_S     = 7'h21;
  localparam logic [6:0] OP_SLL       = 7'h30;
  localparam logic [6:0] OP_SRA       = 7'h32;

  logic              core_clock_i = 1'b0;
  logic              core_reset_ni;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [XLEN-1:0]   a_i;
  logic [XLEN-1:0]   b_i;
  logic [6:0]        op_i;
  logic [1:0]        ew_i;
  logic [ROB_W-1:0]  rob_i;
  logic [DEST_W-1:0] dest_i;
  logic              valid_o;
  logic              ready_i;
  logic              wb_valid_o;
  logic [XLEN-1:0]   result_o;
  logic [ROB_W-1:0]  rob_o;
  logic [DEST_W-1:0] dest_o;

  int n_asserts = 0;
  int n_fail    = 0;

  ivalu_pipelined #(
    .XLEN(XLEN), .STAGES(STAGES), .ROB_W(ROB_W), .DEST_W(DEST_W)
  ) dut (
    .core_clock_i  (core_clock_i),
    .core_reset_ni (core_reset_ni),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .a_i           (a_i),
    .b_i           (b_i),
    .op_i          (op_i),
    .ew_i          (ew_i),
    .rob_i         (rob_i),
    .dest_i        (dest_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .wb_valid_o    (wb_valid_o),
    .result_o      (result_o),
    .rob_o         (rob_o),
    .dest_o        (dest_o)
  );

  always #5 core_clock_i = ~core_clock_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge core_clock_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] op, input logic [1:0] ew,
                       input logic [4:0] rob, input logic [5:0] dest);
    valid_i = v;
    a_i     = a;
    b_i     = b;
    op_i    = op;
    ew_i    = ew;
    rob_i   = rob;
    dest_i  = dest;
  endtask

  // Issue one op with ready_i=1, check the bubble cycles and the retiring beat.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] op, input logic [1:0] ew,
                        input logic [4:0] rob, input logic [5:0] dest,
                        input logic [31:0] exp);
    drive(1'b1, a, b, op, ew, rob, dest);
    step();
    valid_i = 1'b0;
    repeat (STAGES - 1) begin
      settle();
      chk({tag, " bubble"}, {63'd0, valid_o}, 64'd0);
      step();
    end
    settle();
    chk({tag, " valid"}, {63'd0, valid_o}, 64'd1);
    chk({tag, " result"}, {32'd0, result_o}, {32'd0, exp});
    chk({tag, " rob"}, {59'd0, rob_o}, {59'd0, rob});
    chk({tag, " dest"}, {58'd0, dest_o}, {58'd0, dest});
    chk({tag, " wb_valid"}, {63'd0, wb_valid_o}, {63'd0, (dest != 6'd0)});
    $display("op %s: result=0x%08h rob=%0d dest=%0d wb_valid=%0b", tag, result_o, rob_o, dest_o, wb_valid_o);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    core_reset_ni = 1'b0;
    flush_i       = 1'b0;
    ready_i       = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 7'd0, 2'd0, 5'd0, 6'd0);
    #2;
    chk("reset valid_o", {63'd0, valid_o}, 64'd0);
    chk("reset wb_valid_o", {63'd0, wb_valid_o}, 64'd0);
    chk("reset result_o", {32'd0, result_o}, 64'd0);
    chk("reset rob_o", {59'd0, rob_o}, 64'd0);
    chk("reset dest_o", {58'd0, dest_o}, 64'd0);
    chk("reset ready_o", {63'd0, ready_o}, 64'd1);
    step();
    step();
    core_reset_ni = 1'b1;

    // Lane arithmetic vectors
    run_op("add_sat_s ew8",  32'h7F7F7F7F, 32'h01010101, OP_ADD_SAT_S, 2'b00, 5'd1, 6'd1, 32'h7F7F7F7F);
    run_op("sub_sat_u ew16", 32'h00050010, 32'h00070004, OP_SUB_SAT_U, 2'b01, 5'd2, 6'd2, 32'h0000000C);
    run_op("sra ew8",        32'h80808080, 32'h07070707, OP_SRA,       2'b00, 5'd3, 6'd3, 32'hFFFFFFFF);
    run_op("lt_u ew32",      32'h00000001, 32'h00000002, OP_LT_U,      2'b10, 5'd4, 6'd4, 32'hFFFFFFFF);
    run_op("add ew8",        32'hFF010203, 32'h01010101, OP_ADD,       2'b00, 5'd5, 6'd5, 32'h00020304);
    run_op("max_s ew16",     32'h80000001, 32'h0001FFFF, OP_MAX_S,     2'b01, 5'd6, 6'd6, 32'h00010001);
    run_op("avg_u ew8",      32'hFF000102, 32'hFF010304, OP_AVG_U,     2'b00, 5'd7, 6'd7, 32'hFF010203);
    run_op("sll ew16",       32'h00018001, 32'h00110001, OP_SLL,       2'b01, 5'd8, 6'd8, 32'h00020002);
    run_op("eq ew11",        32'h00000005, 32'h00000005, OP_EQ,        2'b11, 5'd9, 6'd9, 32'hFFFFFFFF);
    run_op("add_zero",       32'h00000001, 32'h00000001, OP_ADD_ZERO,  2'b10, 5'd10, 6'd10, 32'h00000000);
    run_op("dest0",          32'h00000003, 32'h00000004, OP_ADD,       2'b10, 5'd11, 6'd0, 32'h00000007);

    // Stall: A,B issued, then ready_i low for 3 cycles while C waits
    drive(1'b1, 32'd1, 32'd100, OP_ADD, 2'b10, 5'd1, 6'd1);
    step();
    drive(1'b1, 32'd2, 32'd100, OP_ADD, 2'b10, 5'd2, 6'd2);
    step();
    ready_i = 1'b0;
    drive(1'b1, 32'd3, 32'd100, OP_ADD, 2'b10, 5'd3, 6'd3);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("stall ready_o", {63'd0, ready_o}, 64'd0);
      chk("stall valid_o", {63'd0, valid_o}, 64'd1);
      chk("stall rob_o", {59'd0, rob_o}, 64'd1);
      chk("stall result_o", {32'd0, result_o}, 64'd101);
      $display("stall cycle %0d: ready_o=%0b rob=%0d result=%0d", c, ready_o, rob_o, result_o);
      step();
    end
    ready_i = 1'b1;
    settle();
    chk("release ready_o", {63'd0, ready_o}, 64'd1);
    chk("retire A rob", {59'd0, rob_o}, 64'd1);
    $display("retire rob=%0d result=%0d", rob_o, result_o);
    step();
    drive(1'b1, 32'd4, 32'd100, OP_ADD, 2'b10, 5'd4, 6'd4);
    settle();
    chk("retire B valid", {63'd0, valid_o}, 64'd1);
    chk("retire B rob", {59'd0, rob_o}, 64'd2);
    chk("retire B result", {32'd0, result_o}, 64'd102);
    $display("retire rob=%0d result=%0d", rob_o, result_o);
    step();
    valid_i = 1'b0;
    settle();
    chk("retire C valid", {63'd0, valid_o}, 64'd1);
    chk("retire C rob", {59'd0, rob_o}, 64'd3);
    chk("retire C result", {32'd0, result_o}, 64'd103);
    $display("retire rob=%0d result=%0d", rob_o, result_o);
    step();
    settle();
    chk("retire D valid", {63'd0, valid_o}, 64'd1);
    chk("retire D rob", {59'd0, rob_o}, 64'd4);
    chk("retire D result", {32'd0, result_o}, 64'd104);
    $display("retire rob=%0d result=%0d", rob_o, result_o);
    step();
    settle();
    chk("stall no duplicate", {63'd0, valid_o}, 64'd0);
    step();

    // Flush: X and Y in flight (held by a stall), Z presented with flush_i
    ready_i = 1'b0;
    drive(1'b1, 32'd5, 32'd0, OP_ADD, 2'b10, 5'd5, 6'd5);
    step();
    drive(1'b1, 32'd6, 32'd0, OP_ADD, 2'b10, 5'd6, 6'd6);
    step();
    drive(1'b1, 32'd7, 32'd0, OP_ADD, 2'b10, 5'd7, 6'd7);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    settle();
    chk("flush clears valid_o", {63'd0, valid_o}, 64'd0);
    $display("flush: valid_o=%0b", valid_o);
    ready_i = 1'b1;
    step();
    settle();
    chk("flush drops Z", {63'd0, valid_o}, 64'd0);
    run_op("after flush", 32'd8, 32'd1, OP_ADD, 2'b10, 5'd8, 6'd8, 32'd9);
    settle();
    chk("after flush drained", {63'd0, valid_o}, 64'd0);

    // Reset asserted mid-pipe
    drive(1'b1, 32'h11, 32'h22, OP_ADD, 2'b10, 5'd9, 6'd9);
    step();
    drive(1'b1, 32'h33, 32'h44, OP_ADD, 2'b10, 5'd10, 6'd10);
    step();
    valid_i = 1'b0;
    ready_i = 1'b0;
    settle();
    chk("pre-reset valid_o", {63'd0, valid_o}, 64'd1);
    core_reset_ni = 1'b0;
    #1;
    chk("mid reset valid_o", {63'd0, valid_o}, 64'd0);
    chk("mid reset wb_valid_o", {63'd0, wb_valid_o}, 64'd0);
    chk("mid reset result_o", {32'd0, result_o}, 64'd0);
    chk("mid reset rob_o", {59'd0, rob_o}, 64'd0);
    chk("mid reset dest_o", {58'd0, dest_o}, 64'd0);
    chk("mid reset ready_o", {63'd0, ready_o}, 64'd1);
    $display("mid-pipe reset: valid_o=%0b result=0x%08h", valid_o, result_o);
    step();
    step();
    core_reset_ni = 1'b1;
    ready_i = 1'b1;
    run_op("after reset", 32'h00000010, 32'h00000020, OP_ADD, 2'b10, 5'd12, 6'd12, 32'h00000030);
    settle();
    chk("after reset drained", {63'd0, valid_o}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ivalu_pipelined.md
IVALU_PIPELINED -- requirements
Module: ivalu_pipelined

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- XLEN, 32, operand width; multiple of 32.
- STAGES, 2, pipeline depth in cycles; legal range 1..3.
- ROB_W, 5, ROB tag width.
- DEST_W, 6, physical destination tag width.
REQ-002 SHALL have ports (name direction width meaning), one per line:
- core_clock_i in 1 clock; one clock.
- core_reset_ni in 1 reset; asynchronous, active-low.
- flush_i in 1 kills all in-flight and incoming ops.
- valid_i in 1 issue strobe.
- ready_o out 1 pipe can accept.
- a_i in XLEN operand A.
- b_i in XLEN operand B.
- op_i in 7 operation code.
- ew_i in 2 element width.
- rob_i in ROB_W tag.
- dest_i in DEST_W tag.
- valid_o out 1 result valid.
- ready_i in 1 writeback consumer ready.
- wb_valid_o out 1 valid_o and dest_o!=0.
- result_o out XLEN packed result.
- rob_o out ROB_W tag.
- dest_o out DEST_W tag.

Function
REQ-003 SHALL decode ew_i as: 00 8-bit lanes; 01 16-bit lanes; 10 and 11 32-bit lanes. Lanes are independent, and no carry or shift crosses a lane boundary.
REQ-004 SHALL select the unit with op_i[5:4]: 00 adder, 01 compare, 10 min/max, 11 shifter.
REQ-005 SHALL implement adder ops on op_i[2:0]:
- 000 add (wrap); 001 sub (wrap).
- 010 signed-saturating add; 011 unsigned-saturating add.
- 100 signed-saturating sub; 101 unsigned-saturating sub.
- 110 unsigned average, (a+b+1)>>1 computed at lane width+1.
- 111 produces 0.
REQ-006 SHALL implement compare ops on op_i[1:0]: 00 eq, 01 signed lt, 10 unsigned lt, 11 produces 0. A true lane is all-ones; a false lane is zero.
REQ-007 SHALL implement min/max ops on op_i[1:0]: 00 signed min, 01 signed max, 10 unsigned min, 11 unsigned max.
REQ-008 SHALL implement shifter ops on op_i[1:0]: 00 sll, 01 srl, 10 sra, 11 produces 0. Shift amount is the low log2(lane width) bits of the matching b lane.
REQ-009 SHALL carry result, rob, dest and valid through exactly STAGES register stages. Latency from an accepted issue to valid_o is STAGES cycles when there is no stall.
REQ-010 SHALL stall globally: advance = !valid_o | ready_i. When advance is 0, every stage holds its contents.
REQ-011 SHALL drive ready_o = advance, combinationally.
REQ-012 SHALL accept an op only when valid_i & ready_o & !flush_i.
REQ-013 SHALL hold result_o, rob_o and dest_o stable while valid_o & !ready_i.
REQ-014 SHALL clear every stage's valid bit, including the output stage, at the edge where flush_i=1. This applies regardless of stall; data fields may keep stale values.
REQ-015 SHALL drop an op presented in the same cycle as flush_i.
REQ-016 SHALL drive wb_valid_o = valid_o & (dest_o!=0).
REQ-017 SHALL fill a bubble on the edge its output is consumed when ready_i=1 and the pipe is full: no dead cycle, sustained throughput of 1 op/cycle.

Reset
REQ-018 SHALL, while core_reset_ni=0, asynchronously force all valid bits, valid_o and wb_valid_o to 0, and result_o, rob_o and dest_o to 0.
REQ-019 SHALL leave ready_o=1 during and after reset. An op issued in the first cycle after release is accepted normally.
REQ-020 SHALL discard in-flight ops when reset is asserted mid-operation; they never appear on valid_o.

Structure
REQ-021 SHALL place unit-select, per-unit op codes and the element-width encodings in shared package ivalu_pkg.
REQ-022 SHALL place all combinational lane arithmetic in one sub-module, ivalu_lanes (a, b, op, ew -> result). The top level holds only the pipeline, stall and flush logic.

Verification
REQ-023 Bench SHALL cover:
- ew=00, op add-sat-signed, a=0x7F7F7F7F, b=0x01010101 -> result 0x7F7F7F7F after STAGES cycles.
- ew=01, op sub-sat-unsigned, a=0x00050010, b=0x00070004 -> result 0x0000000C.
- ew=00, op sra, a=0x80808080, b=0x07070707 -> 0xFFFFFFFF; ew=10, op unsigned lt, a=1, b=2 -> 0xFFFFFFFF.
- Back-to-back issue of 4 ops with ready_i=0 for 3 cycles -> ready_o=0, outputs held stable; after release all 4 retire in order, no loss or duplication.
- flush_i pulsed with 2 ops in flight plus a new valid_i -> no valid_o for any of the 3 ops; the op issued the next cycle retires after STAGES cycles.
- Op with dest_i=0 -> valid_o=1, wb_valid_o=0; core_reset_ni asserted mid-pipe -> all outputs 0 immediately.
